fb_arbiter: RTL and testbench

Frame-buffer port arbiter sharing a single-port synchronous RAM between the DVI capture writer and the EL display scan reader. Display reads are real-time and always win; capture writes are queued in a small write FIFO and drained into the RAM in every cycle the reader leaves free. The block sits between the capture logic, the output scan generator (which supplies `rdPix`/`addr`-style requests) and the frame-buffer RAM.

---
 rtl/fb_arbiter.sv | 114 +++++++++++
 tb/tb_fb_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fb_arbiter.sv
// Frame-buffer port arbiter: display reads always win, capture writes drain via a FIFO.
// Optional FB_DROP_COUNT_EN adds a saturating dropped-write counter output.
module fb_arbiter #(
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 8,
  parameter int FIFO_AW = 4
) (
  input  logic               clock_in,
  input  logic               reset,
  input  logic               rdReq,
  input  logic [ADDR_W-1:0]  rdAddr,
  output logic               rdValid,
  output logic [DATA_W-1:0]  rdData,
  input  logic               wrReq,
  input  logic [ADDR_W-1:0]  wrAddr,
  input  logic [DATA_W-1:0]  wrData,
  output logic               wrFull,
  output logic [FIFO_AW:0]   wrLevel,
  output logic [ADDR_W-1:0]  memAddr,
  output logic               memWe,
  output logic [DATA_W-1:0]  memWData,
  input  logic [DATA_W-1:0]  memRData
`ifdef FB_DROP_COUNT_EN
  ,
  output logic [15:0]        dropCount
`endif
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LVL =
    (FIFO_AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE
  } slot_t;

  slot_t              state;
  logic [ADDR_W-1:0]  qAddr [DEPTH];
  logic [DATA_W-1:0]  qData [DEPTH];
  logic [FIFO_AW-1:0] headPtr;
  logic [FIFO_AW-1:0] tailPtr;
  logic [FIFO_AW:0]   level;
  logic               rdPend;
  logic               push;
  logic               pop;

  assign wrLevel = level;
  assign wrFull  = (level == FULL_LVL);
  // fullness is judged before the same-edge pop
  assign push    = wrReq && !wrFull;
  assign pop     = !rdReq && (level != '0);

  always_ff @(posedge clock_in) begin
    if (push) begin
      qAddr[tailPtr] <= wrAddr;
      qData[tailPtr] <= wrData;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state    <= IDLE;
      memAddr  <= '0;
      memWe    <= 1'b0;
      memWData <= '0;
      rdPend   <= 1'b0;
      rdValid  <= 1'b0;
      rdData   <= '0;
      headPtr  <= '0;
      tailPtr  <= '0;
      level    <= '0;
    end else begin
      rdPend  <= (state == READ);
      rdValid <= rdPend;
      if (rdPend) rdData <= memRData;
      if (push) tailPtr <= tailPtr + 1'b1;
      if (pop) headPtr <= headPtr + 1'b1;
      level <= level
             + (FIFO_AW+1)'(push)
             - (FIFO_AW+1)'(pop);
      unique case (1'b1)
        rdReq: begin
          state   <= READ;
          memAddr <= rdAddr;
          memWe   <= 1'b0;
        end
        pop: begin
          state    <= WRITE;
          memAddr  <= qAddr[headPtr];
          memWData <= qData[headPtr];
          memWe    <= 1'b1;
        end
        default: begin
          state <= IDLE;
          memWe <= 1'b0;
        end
      endcase
    end
  end

`ifdef FB_DROP_COUNT_EN
  always_ff @(posedge clock_in) begin
    if (reset) begin
      dropCount <= '0;
    end else if (wrReq && wrFull
                 && dropCount != 16'hFFFF) begin
      dropCount <= dropCount + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fb_arbiter.sv
// Randomized bench for fb_arbiter with a queue-based reference model
// and a behavioural single-port RAM attached to the memory port.
module tb_fb_arbiter;

  localparam int AW = 15;
  localparam int DW = 8;

  logic          clock_in = 1'b0;
  logic          reset = 1'b1;
  logic          rdReq = 1'b0;
  logic [AW-1:0] rdAddr = '0;
  logic          rdValid;
  logic [DW-1:0] rdData;
  logic          wrReq = 1'b0;
  logic [AW-1:0] wrAddr = '0;
  logic [DW-1:0] wrData = '0;
  logic          wrFull;
  logic [4:0]    wrLevel;
  logic [AW-1:0] memAddr;
  logic          memWe;
  logic [DW-1:0] memWData;
  logic [DW-1:0] memRData = '0;
`ifdef FB_DROP_COUNT_EN
  logic [15:0]   dropCount;
`endif

  fb_arbiter dut (
    .clock_in (clock_in),
    .reset    (reset),
    .rdReq    (rdReq),
    .rdAddr   (rdAddr),
    .rdValid  (rdValid),
    .rdData   (rdData),
    .wrReq    (wrReq),
    .wrAddr   (wrAddr),
    .wrData   (wrData),
    .wrFull   (wrFull),
    .wrLevel  (wrLevel),
    .memAddr  (memAddr),
    .memWe    (memWe),
    .memWData (memWData),
    .memRData (memRData)
`ifdef FB_DROP_COUNT_EN
    ,
    .dropCount(dropCount)
`endif
  );

  always #5 clock_in = ~clock_in;

  logic [DW-1:0] ram [1 << AW];

  always @(posedge clock_in) begin
    if (memWe) ram[memAddr] <= memWData;
    memRData <= ram[memAddr];
  end

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } rd_t;

  logic [DW-1:0] modelRam [1 << AW];
  wr_t           q[$];
  rd_t           pend[$];
  int            cyc = 0;
  int            drops = 0;
  logic          expWe = 1'b0;
  logic [AW-1:0] expAddr = '0;
  logic [DW-1:0] expWData = '0;
  logic          expValid = 1'b0;
  logic [DW-1:0] expRData = '0;

  int nCmp = 0;
  int nBad = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    nCmp++;
    if (obs !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic rst,
                      input logic r,
                      input logic [AW-1:0] ra,
                      input logic w,
                      input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd);
    bit  full;
    wr_t e;
    rd_t p;
    reset  = rst;
    rdReq  = r;
    rdAddr = ra;
    wrReq  = w;
    wrAddr = wa;
    wrData = wd;
    @(posedge clock_in);
    if (rst) begin
      q.delete();
      pend.delete();
      drops    = 0;
      expWe    = 1'b0;
      expAddr  = '0;
      expWData = '0;
      expValid = 1'b0;
      expRData = '0;
    end else begin
      full = (q.size() == 16);
      expValid = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        p = pend.pop_front();
        expValid = 1'b1;
        expRData = p.d;
      end
      if (r) begin
        p.due = cyc + 2;
        p.d   = modelRam[ra];
        pend.push_back(p);
        expAddr = ra;
        expWe   = 1'b0;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        modelRam[e.a] = e.d;
        expAddr  = e.a;
        expWData = e.d;
        expWe    = 1'b1;
      end else begin
        expWe = 1'b0;
      end
      if (w) begin
        if (full) begin
          if (drops < 16'hFFFF) drops++;
        end else begin
          e.a = wa;
          e.d = wd;
          q.push_back(e);
        end
      end
    end
    cyc++;
    #1;
    check("memWe", 32'(memWe), 32'(expWe));
    check("memAddr", 32'(memAddr), 32'(expAddr));
    check("memWData", 32'(memWData), 32'(expWData));
    check("wrLevel", 32'(wrLevel), q.size());
    check("wrFull", 32'(wrFull), 32'(q.size() == 16));
    check("rdValid", 32'(rdValid), 32'(expValid));
    check("rdData", 32'(rdData), 32'(expRData));
`ifdef FB_DROP_COUNT_EN
    check("dropCount", 32'(dropCount), drops);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]      = DW'(i) ^ 8'h5A;
      modelRam[i] = DW'(i) ^ 8'h5A;
    end

    step(1, 0, '0, 0, '0, '0);
    step(1, 0, '0, 0, '0, '0);

    // single read of address 5
    step(0, 1, 15'h0005, 0, '0, '0);
    idle(4);

    // three writes, then read them back
    step(0, 0, '0, 1, 15'h0010, 8'hAA);
    step(0, 0, '0, 1, 15'h0011, 8'hBB);
    step(0, 0, '0, 1, 15'h0012, 8'hCC);
    idle(4);
    for (int i = 0; i < 3; i++)
      step(0, 1, AW'(16 + i), 0, '0, '0);
    idle(4);

    // long read burst while pushing 20 writes
    for (int i = 0; i < 80; i++)
      step(0, 1, AW'(i), i < 20,
           AW'(16'h0100 + i), DW'(8'h30 + i));
    idle(20);

    // fill, then write on the same edge as a pop
    for (int i = 0; i < 16; i++)
      step(0, 1, AW'(i), 1,
           AW'(16'h0200 + i), DW'(i));
    step(0, 0, '0, 1, 15'h0300, 8'hEE);
    idle(18);

    // no forwarding from the FIFO to a read
    step(0, 1, 15'h0020, 1, 15'h0020, 8'h55);
    for (int i = 0; i < 4; i++)
      step(0, 1, 15'h0020, 0, '0, '0);
    idle(3);
    step(0, 1, 15'h0020, 0, '0, '0);
    idle(4);

    // reset with entries queued and a read in flight
    for (int i = 0; i < 8; i++)
      step(0, 1, AW'(i), 1,
           AW'(16'h0400 + i), DW'(8'h90 + i));
    step(1, 1, 15'h0001, 1, 15'h0500, 8'h11);
    idle(4);

    // randomized traffic on a small address window
    for (int blk = 0; blk < 15; blk++) begin
      int rp;
      rp = $urandom_range(20, 90);
      for (int i = 0; i < 200; i++) begin
        step($urandom_range(0, 199) == 0,
             $urandom_range(0, 99) < rp,
             AW'($urandom_range(0, 31)),
             $urandom_range(0, 1) == 1,
             AW'($urandom_range(0, 31)),
             DW'($urandom));
      end
    end
    idle(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nBad);
    $finish;
  end

endmodule
